// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - Execution unit for the 4-bit ALU control code with shift-add multiply
//
// Accepts one operation under a valid/ready handshake, computes single-cycle ops in one
// cycle and MUL as a WIDTH-cycle shift-add, then holds the registered result until taken.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rstn         in   1      asynchronous active-low reset
//   in_valid     in   1      issue stage presents ALU_Control/A/B
//   in_ready     out  1      high only in IDLE
//   ALU_Control  in   4      operation code
//   A, B         in   WIDTH  operands
//   out_valid    out  1      C/Zero hold a completed result (DONE state)
//   out_ready    in   1      consumer takes the result
//   C            out  WIDTH  registered result
//   Zero         out  1      registered, 1 iff C == 0
//   busy         out  1      high in MUL state
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_acc_next;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mult;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_c;
    logic             r_zero;

    // Single-cycle result; illegal codes fall through to zero so they still complete.
    always_comb begin
        w_alu_res = '0;
        case (ALU_Control)
            OP_AND:  w_alu_res = A & B;
            OP_OR:   w_alu_res = A | B;
            OP_ADD:  w_alu_res = A + B;
            OP_SUB:  w_alu_res = A - B;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: w_alu_res = '0;
        endcase
    end

    assign w_acc_next = r_acc + (r_mult[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        w_accept   = 1'b0;
        w_mul_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = (ALU_Control == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_mul_last = 1'b1;
                    w_next     = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mcand <= '0;
            r_mult  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_c     <= '0;
            r_zero  <= 1'b1;
        end else if (w_accept) begin
            if (ALU_Control == OP_MUL) begin
                r_mcand <= A;
                r_mult  <= B;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else begin
                r_c    <= w_alu_res;
                r_zero <= (w_alu_res == '0);
            end
        end else if (r_state == S_MUL) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_mult  <= r_mult >> 1;
            r_cnt   <= r_cnt + 1'b1;
            // Final partial product is folded in on the same edge the result is loaded.
            if (w_mul_last) begin
                r_c    <= w_acc_next;
                r_zero <= (w_acc_next == '0);
            end
        end
    end

    assign C    = r_c;
    assign Zero = r_zero;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - Self-checking bench for alu_seq_exec
module tb_alu_seq_exec;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    ALU_Control = 4'd0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  C;
    logic          Zero;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_exec #(.WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_Control(ALU_Control), .A(A), .B(B), .out_valid(out_valid),
        .out_ready(out_ready), .C(C), .Zero(Zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         z;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Reference model: the operation as plain arithmetic on the operand values.
    function automatic logic [W-1:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint unsigned prod;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return W'(a + b);
            4'b0110: return W'(a - b);
            4'b0111: return (int'(a) < int'(b)) ? W'(1) : W'(0);
            4'b1000: return (a < b) ? W'(1) : W'(0);
            4'b1001: begin
                prod = longint'(a) * longint'(b);
                return prod[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // Issue one op, measure latency and busy cycles, hold backpressure for 'hold' cycles
    // while poking in_valid with junk, then release and confirm return to IDLE.
    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_c, input logic exp_z,
                          input int hold);
        int cycles;
        int bc;
        int guard;
        logic [W-1:0] c_cap;
        logic         z_cap;
        logic         stable;
        logic         no_ready;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({name, " in_ready before issue"}, 64'(in_ready), 64'd1);
        ALU_Control = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        ALU_Control = 4'($urandom);
        A = $urandom;
        B = $urandom;
        cycles = 1;
        bc = 0;
        while (!out_valid && cycles < 200) begin
            if (busy) bc++;
            if (in_ready) bc += 1000;
            @(negedge clk);
            cycles++;
        end
        check({name, " out_valid seen"}, 64'(out_valid), 64'd1);
        check({name, " latency"}, 64'(cycles), (op == 4'b1001) ? 64'(W + 1) : 64'd1);
        check({name, " busy cycles"}, 64'(bc), (op == 4'b1001) ? 64'(W) : 64'd0);
        check({name, " C"}, 64'(C), 64'(exp_c));
        check({name, " Zero"}, 64'(Zero), 64'(exp_z));
        check({name, " in_ready in DONE"}, 64'(in_ready), 64'd0);
        c_cap = C;
        z_cap = Zero;
        stable = 1'b1;
        no_ready = 1'b1;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            ALU_Control = 4'($urandom);
            A = $urandom;
            B = $urandom;
            @(negedge clk);
            if (C !== c_cap || Zero !== z_cap || out_valid !== 1'b1 || busy !== 1'b0) stable = 1'b0;
            if (in_ready !== 1'b0) no_ready = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            check({name, " stable under backpressure"}, 64'(stable), 64'd1);
            check({name, " in_ready low under backpressure"}, 64'(no_ready), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid after take"}, 64'(out_valid), 64'd0);
        check({name, " in_ready after take"}, 64'(in_ready), 64'd1);
    endtask

    vec_t tbl[10];
    logic [3:0] legal_ops[7];

    initial begin
        tbl[0] = '{4'b0010, 32'hFFFF_FFFF, 32'h1,       32'h0,         1'b1};
        tbl[1] = '{4'b0110, 32'h5,         32'h7,       32'hFFFF_FFFE, 1'b0};
        tbl[2] = '{4'b0111, 32'hFFFF_FFFF, 32'h1,       32'h1,         1'b0};
        tbl[3] = '{4'b1000, 32'hFFFF_FFFF, 32'h1,       32'h0,         1'b1};
        tbl[4] = '{4'b0000, 32'hF0F0,      32'hFF00,    32'hF000,      1'b0};
        tbl[5] = '{4'b0001, 32'hF0F0,      32'hFF00,    32'hFFF0,      1'b0};
        tbl[6] = '{4'b1001, 32'd1234,      32'd5678,    32'd7006652,   1'b0};
        tbl[7] = '{4'b1001, 32'h8000_0000, 32'h2,       32'h0,         1'b1};
        tbl[8] = '{4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,       1'b1};
        tbl[9] = '{4'b1111, 32'h1234,      32'h5678,    32'h0,         1'b1};
        legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001};

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset C", 64'(C), 64'd0);
        check("reset Zero", 64'(Zero), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].z,
                   (i == 0) ? 10 : 0);
        end

        // Reset in the middle of a multiply discards it.
        ALU_Control = 4'b1001;
        A = 32'd99;
        B = 32'd77;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid-MUL busy before reset", 64'(busy), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("async reset in_ready", 64'(in_ready), 64'd1);
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset C", 64'(C), 64'd0);
        check("async reset Zero", 64'(Zero), 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (out_valid || busy) seen = 1'b1;
            end
            check("no output after reset release", 64'(seen), 64'd0);
        end

        // Reset while a result is pending also discards it.
        ALU_Control = 4'b0010;
        A = 32'd3;
        B = 32'd4;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pending result valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("reset in DONE out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("reset in DONE stays idle", 64'(out_valid), 64'd0);

        for (int n = 0; n < 150; n++) begin
            logic [3:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] e;
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(10, 15));
            else op = legal_ops[$urandom_range(0, 6)];
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = a;
                1: b = 32'h0;
                default: b = $urandom;
            endcase
            e = ref_model(op, a, b);
            run_op($sformatf("rnd%0d op%0h", n, op), op, a, b, e, (e == '0), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
